pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV32 pipeline.
- Sequences the PC, IF/ID, ID/EX and EX/MEM pipeline buffers.
- Detects load-use hazards, holds the pipeline while the multi-cycle multiplier occupies EX, and flushes IF/ID on taken branches resolved in ID.
- Sits beside the pipeline buffers; drives their write-enable, bubble and flush inputs.

---
 rtl/pipeline_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32 pipeline: load-use
// interlock, multi-cycle MUL hold in EX and IF/ID flush on taken branches.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs2_i,
    input  logic             branch_taken_i,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_rsd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_is_mul_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_bubble_o,
    output logic             exmem_bubble_o,
    output logic             mul_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam bit         MUL_MULTI  = (MUL_LAT > 1);
    // Reload leaves cnt at 0 in the final EX cycle of the MUL.
    localparam logic [3:0] MUL_RELOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_next_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             mul_hit_s;
    logic             load_use_s;
    logic             mul_stall_s;
    logic             mul_done_s;

    // Next-state logic and MUL occupancy tracking.
    always_comb begin
        mul_hit_s    = ex_valid_i & ex_is_mul_i & MUL_MULTI;
        mul_stall_s  = 1'b0;
        mul_done_s   = 1'b0;
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            RUN: begin
                if (mul_hit_s) begin
                    mul_stall_s  = 1'b1;
                    state_next_s = MUL_BUSY;
                    cnt_next_s   = MUL_RELOAD;
                end else begin
                    mul_done_s = ex_valid_i & ex_is_mul_i & ~MUL_MULTI;
                end
            end
            MUL_BUSY: begin
                if (cnt_r != 4'd0) begin
                    mul_stall_s = 1'b1;
                    cnt_next_s  = cnt_r - 4'd1;
                end else begin
                    mul_done_s   = 1'b1;
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = RUN;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Hazard priority: MUL hold, then load-use, then branch flush; all low in reset.
    always_comb begin
        load_use_s = ex_valid_i & ex_is_load_i & (ex_rsd_i != 5'd0) & id_valid_i &
                     ((ex_rsd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rsd_i == id_rs2_i)));
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        mul_done_o     = mul_done_s;
        if (mul_stall_s) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_bubble_o = 1'b1;
        end else if (load_use_s) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end else begin
            ifid_flush_o = 1'b0;
        end
        if (!rst_i) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            ifid_flush_o   = 1'b0;
            idex_write_o   = 1'b0;
            idex_bubble_o  = 1'b0;
            exmem_bubble_o = 1'b0;
            mul_done_o     = 1'b0;
        end else begin
            mul_done_o = mul_done_s;
        end
    end

    // FSM state and MUL down-counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= '0;
        end else if (!pc_write_o && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controllers (MUL_LAT=4/CNT_W=4 and MUL_LAT=1/CNT_W=16)
// checked every cycle against a rule-level model, plus directed literal checks.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, id_uses_rs2 = 1'b0, branch_taken = 1'b0;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rsd = 5'd0;
    logic ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_mul = 1'b0;

    logic pc_w [2], ifid_w [2], ifid_f [2], idex_w [2], idex_b [2], exmem_b [2], mdone [2];
    logic [3:0]  sc0;
    logic [15:0] sc1;

    int total = 0;
    int bad   = 0;

    // Model state: cycles the current MUL has already spent in EX (0 = none).
    int age  [2] = '{0, 0};
    int scnt [2] = '{0, 0};
    int lat  [2] = '{4, 1};
    int smax [2] = '{15, 65535};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs2_i(id_uses_rs2), .branch_taken_i(branch_taken), .ex_valid_i(ex_valid),
        .ex_rsd_i(ex_rsd), .ex_is_load_i(ex_is_load), .ex_is_mul_i(ex_is_mul),
        .pc_write_o(pc_w[0]), .ifid_write_o(ifid_w[0]), .ifid_flush_o(ifid_f[0]),
        .idex_write_o(idex_w[0]), .idex_bubble_o(idex_b[0]), .exmem_bubble_o(exmem_b[0]),
        .mul_done_o(mdone[0]), .stall_cnt_o(sc0));

    pipeline_hazard_ctrl #(.MUL_LAT(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs2_i(id_uses_rs2), .branch_taken_i(branch_taken), .ex_valid_i(ex_valid),
        .ex_rsd_i(ex_rsd), .ex_is_load_i(ex_is_load), .ex_is_mul_i(ex_is_mul),
        .pc_write_o(pc_w[1]), .ifid_write_o(ifid_w[1]), .ifid_flush_o(ifid_f[1]),
        .idex_write_o(idex_w[1]), .idex_bubble_o(idex_b[1]), .exmem_bubble_o(exmem_b[1]),
        .mul_done_o(mdone[1]), .stall_cnt_o(sc1));

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, d, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model; inputs are stable from negedge to posedge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic busy, mstall, lu, stall, done;
            logic e_pc, e_ifw, e_fl, e_idw, e_idb, e_exb, e_dn;
            logic [31:0] act_sc;
            act_sc = (d == 0) ? {28'd0, sc0} : {16'd0, sc1};
            if (!rst) begin
                age[d] = 0;
                scnt[d] = 0;
                {e_pc, e_ifw, e_fl, e_idw, e_idb, e_exb, e_dn} = 7'b0;
            end else begin
                busy   = (age[d] != 0);
                mstall = busy ? (age[d] < lat[d] - 1) : (ex_valid && ex_is_mul && lat[d] > 1);
                done   = busy ? (age[d] == lat[d] - 1) : (ex_valid && ex_is_mul && lat[d] == 1);
                lu     = ex_valid && ex_is_load && ex_rsd != 0 && id_valid &&
                         (ex_rsd == id_rs1 || (id_uses_rs2 && ex_rsd == id_rs2));
                stall  = mstall || lu;
                e_pc  = !stall;
                e_ifw = !stall;
                e_fl  = !stall && branch_taken;
                e_idw = !mstall;
                e_idb = !mstall && lu;
                e_exb = mstall;
                e_dn  = done;
            end
            chk("pc_write", d, 32'(pc_w[d]), 32'(e_pc));
            chk("ifid_write", d, 32'(ifid_w[d]), 32'(e_ifw));
            chk("ifid_flush", d, 32'(ifid_f[d]), 32'(e_fl));
            chk("idex_write", d, 32'(idex_w[d]), 32'(e_idw));
            chk("idex_bubble", d, 32'(idex_b[d]), 32'(e_idb));
            chk("exmem_bubble", d, 32'(exmem_b[d]), 32'(e_exb));
            chk("mul_done", d, 32'(mdone[d]), 32'(e_dn));
            chk("stall_cnt", d, act_sc, 32'(scnt[d]));
            if (rst) begin
                if (busy) age[d] = done ? 0 : age[d] + 1;
                else if (mstall) age[d] = 1;
                if (!e_pc && scnt[d] < smax[d]) scnt[d] = scnt[d] + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_mul = 1'b0; ex_rsd = 5'd0; branch_taken = 1'b0;
    endtask

    initial begin
        int r;
        // Reset held for three cycles.
        idle_ex();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("lit_reset_pc", 0, 32'(pc_w[0]), 32'd0);
            chk("lit_reset_idexw", 0, 32'(idex_w[0]), 32'd0);
            cyc();
        end
        rst = 1'b1;
        sample();
        chk("lit_rel_pc", 0, 32'(pc_w[0]), 32'd1);
        chk("lit_rel_ifidw", 0, 32'(ifid_w[0]), 32'd1);
        chk("lit_rel_idexw", 0, 32'(idex_w[0]), 32'd1);
        chk("lit_rel_cnt", 0, 32'(sc0), 32'd0);

        // lw x5 in EX, add x6,x5,x7 in ID.
        cyc();
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rsd = 5'd5;
        sample();
        chk("lit_lu_pc", 0, 32'(pc_w[0]), 32'd0);
        chk("lit_lu_ifidw", 0, 32'(ifid_w[0]), 32'd0);
        chk("lit_lu_bubble", 0, 32'(idex_b[0]), 32'd1);
        cyc();
        idle_ex();
        sample();
        chk("lit_lu_after_pc", 0, 32'(pc_w[0]), 32'd1);
        chk("lit_lu_cnt", 0, 32'(sc0), 32'd1);

        // Load into x0 never stalls.
        cyc();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rsd = 5'd0; id_rs1 = 5'd0;
        sample();
        chk("lit_x0_pc", 0, 32'(pc_w[0]), 32'd1);

        // Taken branch during a load-use cycle is deferred one cycle.
        cyc();
        ex_rsd = 5'd5; id_rs1 = 5'd5; branch_taken = 1'b1;
        sample();
        chk("lit_br_lu_flush", 0, 32'(ifid_f[0]), 32'd0);
        cyc();
        idle_ex(); branch_taken = 1'b1;
        sample();
        chk("lit_br_after_flush", 0, 32'(ifid_f[0]), 32'd1);
        chk("lit_br_after_pc", 0, 32'(pc_w[0]), 32'd1);

        // MUL held in EX with a load-use-shaped ID (rsd matches rs1, not a load).
        cyc();
        branch_taken = 1'b0;
        ex_valid = 1'b1; ex_is_mul = 1'b1; ex_rsd = 5'd5;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("lit_mul_exmemb", 0, 32'(exmem_b[0]), 32'd1);
            chk("lit_mul_idexw", 0, 32'(idex_w[0]), 32'd0);
            chk("lit_mul_idexb", 0, 32'(idex_b[0]), 32'd0);
            chk("lit_mul_done_lo", 0, 32'(mdone[0]), 32'd0);
            cyc();
        end
        sample();
        chk("lit_mul_done", 0, 32'(mdone[0]), 32'd1);
        chk("lit_mul_done_pc", 0, 32'(pc_w[0]), 32'd1);
        cyc();
        idle_ex();
        sample();
        chk("lit_mul_cnt", 0, 32'(sc0), 32'd5);

        // Reset one cycle into a MUL.
        cyc();
        ex_valid = 1'b1; ex_is_mul = 1'b1;
        cyc();
        rst = 1'b0;
        sample();
        chk("lit_rmid_done", 0, 32'(mdone[0]), 32'd0);
        chk("lit_rmid_pc", 0, 32'(pc_w[0]), 32'd0);
        cyc();
        idle_ex();
        rst = 1'b1;
        sample();
        chk("lit_rmid_rel_pc", 0, 32'(pc_w[0]), 32'd1);
        chk("lit_rmid_rel_done", 0, 32'(mdone[0]), 32'd0);
        chk("lit_rmid_rel_exb", 0, 32'(exmem_b[0]), 32'd0);

        // Back-to-back MULs saturate the 4-bit counter.
        cyc();
        ex_valid = 1'b1; ex_is_mul = 1'b1;
        for (int i = 0; i < 28; i++) cyc();
        idle_ex();
        sample();
        chk("lit_sat_cnt", 0, 32'(sc0), 32'd15);

        // Randomized traffic with small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst          = ($urandom_range(0, 199) != 0);
            id_valid     = ($urandom_range(0, 7) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 4) == 0);
            ex_valid     = ($urandom_range(0, 5) != 0);
            ex_rsd       = 5'($urandom_range(0, 3));
            r            = $urandom_range(0, 7);
            ex_is_mul    = (r == 0);
            ex_is_load   = (r >= 1 && r <= 3);
        end
        cyc();
        rst = 1'b1;
        idle_ex();
        sample();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
